// File: rtl/cpu_pkg.sv
// Shared CPU fetch-path types and constants: FSM state encoding, PC width,
// branch offset width and the default reset vector.
package cpu_pkg;

  localparam int PC_W     = 32;
  localparam int OFFSET_W = 8;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bundle: hold/redirect controls in, fetch address and status out.
// slave is the sequencer side; master is the driver (control/hazard/memory side).
interface pc_fetch_sequencer_if;
  import cpu_pkg::*;

  logic                imem_busy;
  logic                stall;
  logic                branch_taken;
  logic [OFFSET_W-1:0] branch_offset;
  logic                jump;
  logic [PC_W-1:0]     jump_target;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_plus4;
  logic                instr_req;
  logic                redirect_pending;
  state_e              state;

  modport slave (
    input  imem_busy, stall, branch_taken, branch_offset, jump, jump_target,
    output pc, pc_plus4, instr_req, redirect_pending, state
  );

  modport master (
    output imem_busy, stall, branch_taken, branch_offset, jump, jump_target,
    input  pc, pc_plus4, instr_req, redirect_pending, state
  );

endinterface

// File: rtl/branch_target_adder.sv
// Combinational PC+4 and branch target (PC+4 plus sign-extended word offset).
// Zero latency; pure arithmetic, wraps mod 2^32.
module branch_target_adder
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]     pc_i,
  input  logic [OFFSET_W-1:0] offset_i,
  output logic [PC_W-1:0]     pc_plus4_o,
  output logic [PC_W-1:0]     branch_target_o
);

  logic [PC_W-1:0] offset_bytes;

  // Word offset to byte offset: sign-extend then shift left by two.
  assign offset_bytes    = {{(PC_W-OFFSET_W-2){offset_i[OFFSET_W-1]}}, offset_i, 2'b00};
  assign pc_plus4_o      = pc_i + PC_W'(4);
  assign branch_target_o = pc_plus4_o + offset_bytes;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: one fetch per cycle, holds on IMEM busy/stall,
// applies jump/branch redirects and buffers a redirect seen while holding.
module pc_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pc_fetch_sequencer_if.slave  fetch
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_tgt;
  logic [PC_W-1:0] redirect_tgt;
  logic            redirect_vld;
  logic            advance;

  branch_target_adder u_bta (
    .pc_i            (pc_q),
    .offset_i        (fetch.branch_offset),
    .pc_plus4_o      (pc_plus4),
    .branch_target_o (branch_tgt)
  );

  assign advance      = !fetch.imem_busy && !fetch.stall;
  assign redirect_vld = fetch.jump || fetch.branch_taken;
  // Jump wins over a simultaneous taken branch; low address bits are forced to zero.
  assign redirect_tgt = fetch.jump ? (fetch.jump_target & ~PC_W'(3)) : branch_tgt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (advance) begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (redirect_vld)     pc_d = redirect_tgt;
          else if (pend_q)      pc_d = pend_tgt_q;
          else                  pc_d = pc_plus4;
        end else begin
          state_d = HOLD;
          // Latest redirect wins while the PC is frozen.
          if (redirect_vld) begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_tgt;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign fetch.pc               = pc_q;
  assign fetch.pc_plus4         = pc_plus4;
  assign fetch.instr_req        = (state_q != BOOT);
  assign fetch.redirect_pending = pend_q;
  assign fetch.state            = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios then randomized traffic,
// all compared against a behavioural PC model.
module tb_pc_fetch_sequencer;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model state
  logic [31:0] exp_pc;
  logic        exp_pend;
  logic [31:0] exp_tgt;
  state_e      exp_state;

  pc_fetch_sequencer_if fetch_if ();

  pc_fetch_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fetch  (fetch_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 32'h0;
    exp_pend  = 1'b0;
    exp_tgt   = 32'h0;
    exp_state = BOOT;
  endtask

  // Applies the sequencing rules to the inputs present at the clock edge.
  task automatic model_step();
    logic        adv;
    logic        redir;
    logic [31:0] tgt;
    if (exp_state == BOOT) begin
      exp_state = RUN;
      return;
    end
    adv   = !fetch_if.imem_busy && !fetch_if.stall;
    redir = fetch_if.jump || fetch_if.branch_taken;
    if (fetch_if.jump)
      tgt = {fetch_if.jump_target[31:2], 2'b00};
    else
      tgt = exp_pc + 32'd4 + 32'(int'(signed'(fetch_if.branch_offset)) * 4);
    if (adv) begin
      if (redir)         exp_pc = tgt;
      else if (exp_pend) exp_pc = exp_tgt;
      else               exp_pc = exp_pc + 32'd4;
      exp_pend  = 1'b0;
      exp_state = RUN;
    end else begin
      exp_state = HOLD;
      if (redir) begin
        exp_pend = 1'b1;
        exp_tgt  = tgt;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},    fetch_if.pc, exp_pc);
    chk({tag, ".pc4"},   fetch_if.pc_plus4, exp_pc + 32'd4);
    chk({tag, ".req"},   32'(fetch_if.instr_req), 32'(exp_state != BOOT));
    chk({tag, ".pend"},  32'(fetch_if.redirect_pending), 32'(exp_pend));
    chk({tag, ".state"}, 32'(fetch_if.state), 32'(exp_state));
  endtask

  // Called at a negedge: drive inputs, check, clock once, update model, return at negedge.
  task automatic cyc(input logic busy, input logic stl, input logic bt,
                     input logic [7:0] off, input logic jmp, input logic [31:0] jt);
    fetch_if.imem_busy     = busy;
    fetch_if.stall         = stl;
    fetch_if.branch_taken  = bt;
    fetch_if.branch_offset = off;
    fetch_if.jump          = jmp;
    fetch_if.jump_target   = jt;
    #1;
    compare_all("cyc");
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic adv_cyc();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic jmp_to(input logic [31:0] a);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    fetch_if.imem_busy     = 1'b0;
    fetch_if.stall         = 1'b0;
    fetch_if.branch_taken  = 1'b0;
    fetch_if.branch_offset = 8'h00;
    fetch_if.jump          = 1'b0;
    fetch_if.jump_target   = 32'h0;
    model_reset();
    #3;
    compare_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot sequence: 0 (BOOT), 0 (RUN), then 4, 8, 12
    adv_cyc();
    chk("boot_run_pc", fetch_if.pc, 32'h0);
    chk("boot_run_req", 32'(fetch_if.instr_req), 32'd1);
    adv_cyc();
    chk("inc4", fetch_if.pc, 32'h4);
    adv_cyc();
    adv_cyc();
    chk("inc12", fetch_if.pc, 32'hC);

    // IMEM busy hold
    jmp_to(32'h10);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("hold_pc", fetch_if.pc, 32'h10);
    chk("hold_state", 32'(fetch_if.state), 32'(HOLD));
    chk("hold_req", 32'(fetch_if.instr_req), 32'd1);
    adv_cyc();
    chk("hold_release", fetch_if.pc, 32'h14);

    // Branches relative to PC+4
    jmp_to(32'h20);
    cyc(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 32'h0);
    chk("br_neg", fetch_if.pc, 32'h1C);
    jmp_to(32'h20);
    cyc(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 32'h0);
    chk("br_pos", fetch_if.pc, 32'h30);

    // Redirect during stall is buffered, then applied on release
    jmp_to(32'h40);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h103);
    chk("pend_set", 32'(fetch_if.redirect_pending), 32'd1);
    chk("pend_pc", fetch_if.pc, 32'h40);
    adv_cyc();
    chk("pend_apply", fetch_if.pc, 32'h100);
    chk("pend_clear", 32'(fetch_if.redirect_pending), 32'd0);

    // Jump priority and wraparound
    cyc(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 32'h200);
    chk("jmp_prio", fetch_if.pc, 32'h200);
    jmp_to(32'hFFFF_FFFC);
    adv_cyc();
    chk("wrap", fetch_if.pc, 32'h0);

    // Async reset with a redirect pending in HOLD
    jmp_to(32'h40);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'h80);
    fetch_if.jump = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", fetch_if.pc, 32'h0);
    chk("arst_pend", 32'(fetch_if.redirect_pending), 32'd0);
    chk("arst_state", 32'(fetch_if.state), 32'(BOOT));
    @(negedge clk);
    rst_n = 1'b1;
    adv_cyc();

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] jt;
      if ($urandom_range(0, 79) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      jt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0, 8'($urandom),
          $urandom_range(0, 6) == 0, jt);
    end
    #1;
    compare_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
